// File: rtl/mem_channel_arbiter.sv
// N-channel TX arbiter and in-order RX reply router for memory_interface.
// Reply-bearing commands record their channel in a tag FIFO; RX strobes follow the FIFO head.
module mem_channel_arbiter #(
  parameter int NCH             = 2,
  parameter int IO_BITS         = 2,
  parameter int CMD_BITS        = 2,
  parameter int MAX_OUTSTANDING = 7,
  parameter int ARB_MODE        = 0,
  localparam int CW             = $clog2(NCH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          ch_cmd_valid,
  input  logic [NCH*CMD_BITS-1:0] ch_cmd,
  input  logic [NCH*IO_BITS-1:0]  ch_data,
  input  logic [NCH-1:0]          ch_reserve,
  input  logic [NCH-1:0]          ch_reply_wanted,
  output logic                    tx_command_valid,
  output logic [CMD_BITS-1:0]     tx_command,
  output logic [IO_BITS-1:0]      tx_data,
  input  logic                    tx_command_started,
  input  logic                    tx_active,
  input  logic                    tx_data_next,
  input  logic                    tx_done,
  input  logic                    rx_started,
  input  logic                    rx_active,
  input  logic                    rx_sbs_valid,
  input  logic                    rx_data_valid,
  input  logic                    rx_done,
  output logic [NCH-1:0]          ch_tx_command_started,
  output logic [NCH-1:0]          ch_tx_active,
  output logic [NCH-1:0]          ch_tx_data_next,
  output logic [NCH-1:0]          ch_tx_done,
  output logic [NCH-1:0]          ch_rx_started,
  output logic [NCH-1:0]          ch_rx_active,
  output logic [NCH-1:0]          ch_rx_sbs_valid,
  output logic [NCH-1:0]          ch_rx_data_valid,
  output logic [NCH-1:0]          ch_rx_done,
  output logic [CW-1:0]           tx_owner,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    rx_orphan
);

  localparam int PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d, sel;
  logic [CW-1:0]   tag_mem_q [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            rx_orphan_q;
  logic [NCH-1:0]  req, owner_oh, head_oh;
  logic            owner_valid, owner_reply, push, pop, rx_any;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req = ch_cmd_valid | ch_reserve;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel = owner_q;
    if (!ch_reserve[owner_q]) begin
      if (ARB_MODE == 0) begin
        for (int i = 0; i < NCH; i++)
          if (req[i]) sel = CW'(i);
      end else begin
        // Walk backwards so the channel closest to rr_ptr is the last (winning) assignment.
        for (int k = NCH - 1; k >= 0; k--) begin
          int idx;
          idx = int'(rr_ptr_q) + k;
          if (idx >= NCH) idx = idx - NCH;
          if (req[CW'(idx)]) sel = CW'(idx);
        end
      end
    end
  end

  // The next owner is also the live owner: frozen while a transaction occupies TX.
  assign owner_d  = tx_active ? owner_q : sel;
  assign tx_owner = owner_d;

  always_comb begin
    owner_valid = 1'b0;
    owner_reply = 1'b0;
    tx_command  = '0;
    tx_data     = '0;
    for (int i = 0; i < NCH; i++) begin
      if (owner_d == CW'(i)) begin
        owner_valid = ch_cmd_valid[i];
        owner_reply = ch_reply_wanted[i];
        tx_command  = ch_cmd[i*CMD_BITS +: CMD_BITS];
        tx_data     = ch_data[i*IO_BITS +: IO_BITS];
      end
    end
  end

  assign fifo_full        = (count_q == CNTW'(MAX_OUTSTANDING));
  assign fifo_empty       = (count_q == '0);
  assign tx_command_valid = owner_valid && !fifo_full;

  assign rx_any = rx_started | rx_sbs_valid | rx_data_valid | rx_done;
  assign pop    = rx_done && !fifo_empty;
  assign push   = tx_command_started && owner_reply && (!fifo_full || pop);

  assign owner_oh = {{(NCH-1){1'b0}}, 1'b1} << owner_d;
  assign head_oh  = fifo_empty ? '0 : ({{(NCH-1){1'b0}}, 1'b1} << tag_mem_q[rd_ptr_q]);

  assign ch_tx_command_started = {NCH{tx_command_started}} & owner_oh;
  assign ch_tx_active          = {NCH{tx_active}}          & owner_oh;
  assign ch_tx_data_next       = {NCH{tx_data_next}}       & owner_oh;
  assign ch_tx_done            = {NCH{tx_done}}            & owner_oh;
  assign ch_rx_started         = {NCH{rx_started}}         & head_oh;
  assign ch_rx_active          = {NCH{rx_active}}          & head_oh;
  assign ch_rx_sbs_valid       = {NCH{rx_sbs_valid}}       & head_oh;
  assign ch_rx_data_valid      = {NCH{rx_data_valid}}      & head_oh;
  assign ch_rx_done            = {NCH{rx_done}}            & head_oh;
  assign rx_orphan             = rx_orphan_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (tx_command_started)
      rr_ptr_d = (owner_d == CW'(NCH - 1)) ? '0 : owner_d + 1'b1;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNTW'(1);
    else if (pop && !push) count_d = count_q - CNTW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rx_orphan_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (rx_any && fifo_empty) rx_orphan_q <= 1'b1;
    end
  end

  // NOTE: tag storage is not reset; an entry is only read after being written, guarded by count_q.
  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= owner_d;
  end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Bench for mem_channel_arbiter: a 4-channel round-robin and a 2-channel fixed-priority instance,
// checked every cycle against a queue-based reference model plus directed scenario checks.
module tb_mem_channel_arbiter;

  typedef struct packed {
    logic       reset;
    logic [3:0] valid, reserve, reply;
    logic [7:0] cmd, data;
    logic       tx_cs, tx_act, tx_dn, tx_done;
    logic       rx_st, rx_act, rx_sbs, rx_dv, rx_done;
  } stim_t;

  typedef struct packed {
    logic       cv;
    logic [1:0] cmd, data, owner;
    logic       full, empty, orphan;
    logic [3:0] t_cs, t_act, t_dn, t_done, r_st, r_act, r_sbs, r_dv, r_done;
  } obs_t;

  logic  clk;
  stim_t s0, s1;
  obs_t  o0, o1;
  int    n_checks, n_fail;

  // instance 0: NCH=4 round-robin, depth 3
  logic       r_cv, r_full, r_empty, r_orph;
  logic [1:0] r_cmd, r_data, r_owner;
  logic [3:0] r_tcs, r_tact, r_tdn, r_tdone, r_rst, r_ract, r_rsbs, r_rdv, r_rdone;
  // instance 1: NCH=2 fixed priority, depth 7
  logic       f_cv, f_full, f_empty, f_orph;
  logic [1:0] f_cmd, f_data;
  logic [0:0] f_owner;
  logic [1:0] f_tcs, f_tact, f_tdn, f_tdone, f_rst, f_ract, f_rsbs, f_rdv, f_rdone;

  mem_channel_arbiter #(.NCH(4), .IO_BITS(2), .CMD_BITS(2), .MAX_OUTSTANDING(3), .ARB_MODE(1)) u_rr (
    .clk(clk), .reset(s0.reset),
    .ch_cmd_valid(s0.valid), .ch_cmd(s0.cmd), .ch_data(s0.data),
    .ch_reserve(s0.reserve), .ch_reply_wanted(s0.reply),
    .tx_command_valid(r_cv), .tx_command(r_cmd), .tx_data(r_data),
    .tx_command_started(s0.tx_cs), .tx_active(s0.tx_act), .tx_data_next(s0.tx_dn), .tx_done(s0.tx_done),
    .rx_started(s0.rx_st), .rx_active(s0.rx_act), .rx_sbs_valid(s0.rx_sbs),
    .rx_data_valid(s0.rx_dv), .rx_done(s0.rx_done),
    .ch_tx_command_started(r_tcs), .ch_tx_active(r_tact), .ch_tx_data_next(r_tdn), .ch_tx_done(r_tdone),
    .ch_rx_started(r_rst), .ch_rx_active(r_ract), .ch_rx_sbs_valid(r_rsbs),
    .ch_rx_data_valid(r_rdv), .ch_rx_done(r_rdone),
    .tx_owner(r_owner), .fifo_full(r_full), .fifo_empty(r_empty), .rx_orphan(r_orph)
  );

  mem_channel_arbiter #(.NCH(2), .IO_BITS(2), .CMD_BITS(2), .MAX_OUTSTANDING(7), .ARB_MODE(0)) u_fp (
    .clk(clk), .reset(s1.reset),
    .ch_cmd_valid(s1.valid[1:0]), .ch_cmd(s1.cmd[3:0]), .ch_data(s1.data[3:0]),
    .ch_reserve(s1.reserve[1:0]), .ch_reply_wanted(s1.reply[1:0]),
    .tx_command_valid(f_cv), .tx_command(f_cmd), .tx_data(f_data),
    .tx_command_started(s1.tx_cs), .tx_active(s1.tx_act), .tx_data_next(s1.tx_dn), .tx_done(s1.tx_done),
    .rx_started(s1.rx_st), .rx_active(s1.rx_act), .rx_sbs_valid(s1.rx_sbs),
    .rx_data_valid(s1.rx_dv), .rx_done(s1.rx_done),
    .ch_tx_command_started(f_tcs), .ch_tx_active(f_tact), .ch_tx_data_next(f_tdn), .ch_tx_done(f_tdone),
    .ch_rx_started(f_rst), .ch_rx_active(f_ract), .ch_rx_sbs_valid(f_rsbs),
    .ch_rx_data_valid(f_rdv), .ch_rx_done(f_rdone),
    .tx_owner(f_owner), .fifo_full(f_full), .fifo_empty(f_empty), .rx_orphan(f_orph)
  );

  assign o0 = {r_cv, r_cmd, r_data, r_owner, r_full, r_empty, r_orph,
               r_tcs, r_tact, r_tdn, r_tdone, r_rst, r_ract, r_rsbs, r_rdv, r_rdone};
  assign o1 = {f_cv, f_cmd, f_data, 1'b0, f_owner, f_full, f_empty, f_orph,
               2'b0, f_tcs, 2'b0, f_tact, 2'b0, f_tdn, 2'b0, f_tdone,
               2'b0, f_rst, 2'b0, f_ract, 2'b0, f_rsbs, 2'b0, f_rdv, 2'b0, f_rdone};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_owner [2];
  int m_rr    [2];
  bit m_orph  [2];
  int q0[$];
  int q1[$];

  function automatic int nch(input int d); return (d == 0) ? 4 : 2; endfunction
  function automatic int mx(input int d);  return (d == 0) ? 3 : 7; endfunction
  function automatic int qsize(input int d); return (d == 0) ? q0.size() : q1.size(); endfunction
  function automatic int qfront(input int d); return (d == 0) ? q0[0] : q1[0]; endfunction
  function automatic void qpush(input int d, input int v);
    if (d == 0) q0.push_back(v); else q1.push_back(v);
  endfunction
  function automatic void qpop(input int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  function automatic int m_sel(input int d, input stim_t s);
    logic [3:0] req;
    int n, c;
    req = s.valid | s.reserve;
    n = nch(d);
    if (s.reserve[m_owner[d]]) return m_owner[d];
    if (d == 1) begin
      for (int i = n - 1; i >= 0; i--) if (req[i]) return i;
    end else begin
      for (int k = 0; k < n; k++) begin
        c = (m_rr[d] + k) % n;
        if (req[c]) return c;
      end
    end
    return m_owner[d];
  endfunction

  function automatic obs_t m_obs(input int d, input stim_t s);
    obs_t o;
    int own, sz;
    logic [3:0] oh, hh;
    own = s.tx_act ? m_owner[d] : m_sel(d, s);
    sz  = qsize(d);
    oh  = 4'b0001 << own;
    hh  = (sz == 0) ? 4'b0000 : (4'b0001 << qfront(d));
    o.cv     = s.valid[own] && (sz != mx(d));
    o.cmd    = s.cmd[own*2 +: 2];
    o.data   = s.data[own*2 +: 2];
    o.owner  = 2'(own);
    o.full   = (sz == mx(d));
    o.empty  = (sz == 0);
    o.orphan = m_orph[d];
    o.t_cs   = s.tx_cs   ? oh : 4'b0;
    o.t_act  = s.tx_act  ? oh : 4'b0;
    o.t_dn   = s.tx_dn   ? oh : 4'b0;
    o.t_done = s.tx_done ? oh : 4'b0;
    o.r_st   = s.rx_st   ? hh : 4'b0;
    o.r_act  = s.rx_act  ? hh : 4'b0;
    o.r_sbs  = s.rx_sbs  ? hh : 4'b0;
    o.r_dv   = s.rx_dv   ? hh : 4'b0;
    o.r_done = s.rx_done ? hh : 4'b0;
    return o;
  endfunction

  function automatic void m_step(input int d, input stim_t s);
    int own, sz;
    bit pop, any;
    if (s.reset) begin
      m_owner[d] = 0; m_rr[d] = 0; m_orph[d] = 0;
      if (d == 0) q0.delete(); else q1.delete();
      return;
    end
    own = s.tx_act ? m_owner[d] : m_sel(d, s);
    sz  = qsize(d);
    any = s.rx_st | s.rx_sbs | s.rx_dv | s.rx_done;
    pop = s.rx_done && (sz > 0);
    if (any && sz == 0) m_orph[d] = 1'b1;
    m_owner[d] = own;
    if (pop) qpop(d);
    if (s.tx_cs) begin
      m_rr[d] = (own + 1) % nch(d);
      if (s.reply[own] && (sz < mx(d) || pop)) qpush(d, own);
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check("model_rr", 64'(o0), 64'(m_obs(0, s0)));
    check("model_fp", 64'(o1), 64'(m_obs(1, s1)));
  endtask

  task automatic adv();
    @(posedge clk);
    m_step(0, s0);
    m_step(1, s1);
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic rand_stim(input int d, output stim_t s);
    obs_t e;
    s = '0;
    s.valid   = 4'($urandom);
    s.reserve = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
    s.reply   = 4'($urandom);
    s.cmd     = 8'($urandom);
    s.data    = 8'($urandom);
    s.tx_act  = ($urandom_range(0, 2) == 0);
    s.tx_dn   = 1'($urandom);
    s.tx_done = 1'($urandom);
    s.rx_act  = 1'($urandom);
    s.reset   = ($urandom_range(0, 199) == 0);
    if (qsize(d) > 0) begin
      s.rx_st   = 1'($urandom);
      s.rx_sbs  = 1'($urandom);
      s.rx_dv   = 1'($urandom);
      s.rx_done = ($urandom_range(0, 2) == 0);
    end
    e = m_obs(d, s);
    s.tx_cs = e.cv && ($urandom_range(0, 1) == 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ec;
    logic [3:0] oh;
    n_checks = 0;
    n_fail   = 0;
    s0 = '0; s1 = '0;
    s0.reset = 1'b1; s1.reset = 1'b1;
    adv(); adv();
    s0.reset = 1'b0; s1.reset = 1'b0;
    settle();
    check("rst_empty", 64'(r_empty), 64'(1));
    check("rst_full", 64'(r_full), 64'(0));
    check("rst_orphan", 64'(f_orph), 64'(0));
    check("rst_owner", 64'(f_owner), 64'(0));
    adv();

    // round-robin: all four valid, eight reads in rotation, replies routed in order
    s0.valid = 4'hF; s0.reply = 4'hF;
    for (int k = 0; k < 8; k++) begin
      ec = k % 4;
      oh = 4'b0001 << ec;
      s0.tx_cs = 1'b1;
      settle(); check("rr_owner", 64'(r_owner), 64'(ec)); check("rr_txcs", 64'(r_tcs), 64'(oh)); adv();
      s0.tx_cs = 1'b0; s0.tx_act = 1'b1; s0.tx_done = 1'b1;
      settle(); check("rr_txdone", 64'(r_tdone), 64'(oh)); adv();
      s0.tx_act = 1'b0; s0.tx_done = 1'b0; s0.rx_st = 1'b1; s0.rx_dv = 1'b1;
      settle(); check("rr_rxst", 64'(r_rst), 64'(oh)); check("rr_rxdv", 64'(r_rdv), 64'(oh)); adv();
      s0.rx_st = 1'b0; s0.rx_dv = 1'b0; s0.rx_done = 1'b1;
      settle(); check("rr_rxdone", 64'(r_rdone), 64'(oh)); adv();
      s0.rx_done = 1'b0;
    end

    // ch0 holds reserve over two transactions while ch1 waits
    s0.reply = 4'b0; s0.valid = 4'b0011; s0.reserve = 4'b0001;
    for (int t = 0; t < 2; t++) begin
      s0.tx_cs = 1'b1;
      settle(); check("rsv_start", 64'(r_owner), 64'(0)); adv();
      s0.tx_cs = 1'b0; s0.tx_act = 1'b1;
      settle(); check("rsv_active", 64'(r_owner), 64'(0)); adv();
      s0.tx_act = 1'b0;
      settle(); check("rsv_idle", 64'(r_owner), 64'(0)); adv();
    end
    s0.reserve = 4'b0; s0.tx_cs = 1'b1;
    settle(); check("rsv_release", 64'(r_owner), 64'(1)); check("rsv_rel_cs", 64'(r_tcs), 64'(4'b0010)); adv();
    s0 = '0;

    // fixed priority: ch1 wins, ch0 only after ch1 drops and tx_active falls
    s1.valid = 4'b0011; s1.reply = 4'b0011; s1.tx_cs = 1'b1;
    settle(); check("fp_owner", 64'(f_owner), 64'(1)); check("fp_txcs", 64'(f_tcs), 64'(2'b10)); adv();
    s1.tx_cs = 1'b0; s1.tx_act = 1'b1; s1.valid = 4'b0001;
    settle(); check("fp_hold", 64'(f_owner), 64'(1)); check("fp_cv_hold", 64'(f_cv), 64'(0)); adv();
    s1.tx_done = 1'b1;
    settle(); check("fp_txdone", 64'(f_tdone), 64'(2'b10)); adv();
    s1.tx_done = 1'b0; s1.tx_act = 1'b0; s1.tx_cs = 1'b1;
    settle(); check("fp_next", 64'(f_owner), 64'(0)); check("fp_next_cv", 64'(f_cv), 64'(1)); adv();
    s1.tx_cs = 1'b0; s1.valid = 4'b0; s1.rx_done = 1'b1;
    settle(); check("fp_rx_first", 64'(f_rdone), 64'(2'b10)); adv();
    settle(); check("fp_rx_second", 64'(f_rdone), 64'(2'b01)); adv();
    s1 = '0;

    // depth-3 full gating, then push and pop in the same cycle at count 2
    s0.reset = 1'b1; tick(); s0.reset = 1'b0;
    s0.valid = 4'hF; s0.reply = 4'hF;
    for (int k = 0; k < 3; k++) begin
      s0.tx_cs = 1'b1; tick();
    end
    s0.tx_cs = 1'b0;
    settle(); check("full_flag", 64'(r_full), 64'(1)); check("full_gate", 64'(r_cv), 64'(0)); adv();
    s0.rx_done = 1'b1;
    settle(); check("full_pop_head", 64'(r_rdone), 64'(4'b0001)); check("full_gate_pop", 64'(r_cv), 64'(0)); adv();
    s0.rx_done = 1'b0;
    settle(); check("full_reopen", 64'(r_cv), 64'(1)); check("full_clear", 64'(r_full), 64'(0)); adv();
    s0.tx_cs = 1'b1; s0.rx_done = 1'b1;
    settle(); check("pp_head", 64'(r_rdone), 64'(4'b0010)); check("pp_owner", 64'(r_owner), 64'(3)); adv();
    s0.tx_cs = 1'b0; s0.rx_done = 1'b0; s0.rx_st = 1'b1;
    settle(); check("pp_route", 64'(r_rst), 64'(4'b0100)); check("pp_not_full", 64'(r_full), 64'(0)); adv();
    s0.rx_st = 1'b0; s0.rx_done = 1'b1;
    tick(); tick();
    s0.rx_done = 1'b0;
    settle(); check("drained", 64'(r_empty), 64'(1)); adv();

    // reset mid-transaction drops the pending tag; its reply becomes an orphan
    s0.tx_cs = 1'b1; tick();
    s0.tx_cs = 1'b0; s0.tx_act = 1'b1; s0.reset = 1'b1; tick();
    s0.reset = 1'b0; s0.tx_act = 1'b0; s0.valid = 4'b0; s0.rx_st = 1'b1;
    settle(); check("orph_gate", 64'(r_rst), 64'(0)); adv();
    s0.rx_st = 1'b0;
    settle(); check("orph_set", 64'(r_orph), 64'(1)); adv();
    tick();
    s0.reset = 1'b1; tick(); s0.reset = 1'b0;
    settle(); check("orph_clear", 64'(r_orph), 64'(0)); adv();

    // randomized traffic on both instances
    for (int c = 0; c < 600; c++) begin
      rand_stim(0, s0);
      rand_stim(1, s1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_channel_arbiter.md
# mem_channel_arbiter

N-channel arbiter and reply router between transaction sources (prefetcher, decoder/scheduler, future DMA/debug ports) and `memory_interface`. Selects one channel to own the TX channel per transaction, muxes its command/data, and gates the memory interface strobes to that channel only. Records the issuing channel of every reply-bearing transaction in an in-order tag FIFO and routes RX strobes to the channel at the FIFO head. Generalises the fixed two-source prefetch/scheduler selection to NCH channels, with selectable fixed-priority or round-robin arbitration and orphan-reply detection.

## Interface
- `NCH`, 2: number of channels (2..8); `CW = $clog2(NCH)`.
- `IO_BITS`, 2: TX data width per cycle.
- `CMD_BITS`, 2: TX command width (`TX_CMD_BITS`).
- `MAX_OUTSTANDING`, 7: tag FIFO depth (1..15).
- `ARB_MODE`, 0: 0 = fixed priority (highest index wins), 1 = round-robin.

- `clk` in 1: clock; one clock domain.
- `reset` in 1: synchronous, active-high.
- `ch_cmd_valid` in NCH: channel i has a command.
- `ch_cmd` in NCH*CMD_BITS: channel i command, slice [i*CMD_BITS +: CMD_BITS].
- `ch_data` in NCH*IO_BITS: channel i TX payload.
- `ch_reserve` in NCH: channel i locks the TX channel between transactions.
- `ch_reply_wanted` in NCH: channel i's command gets an RX reply.
- `tx_command_valid` out 1; `tx_command` out CMD_BITS; `tx_data` out IO_BITS: to memory interface.
- `tx_command_started`, `tx_active`, `tx_data_next`, `tx_done` in 1 each: from memory interface.
- `rx_started`, `rx_active`, `rx_sbs_valid`, `rx_data_valid`, `rx_done` in 1 each: from memory interface.
- `ch_tx_command_started`, `ch_tx_active`, `ch_tx_data_next`, `ch_tx_done` out NCH each: TX strobes gated to owner.
- `ch_rx_started`, `ch_rx_active`, `ch_rx_sbs_valid`, `ch_rx_data_valid`, `ch_rx_done` out NCH each: RX strobes gated to head tag.
- `tx_owner` out CW: current TX owner.
- `fifo_full`, `fifo_empty` out 1: tag FIFO status.
- `rx_orphan` out 1: sticky; RX activity with empty FIFO.

## Operation
- Candidate `sel` (combinational): if `ch_reserve[owner_q]`, sel = owner_q; else highest-priority channel with `ch_cmd_valid|ch_reserve`; if none, sel = owner_q.
- Fixed priority: highest index wins. Round-robin: search starts at `rr_ptr`, wrapping modulo NCH.
- `tx_owner = tx_active ? owner_q : sel`; `owner_q <= sel` every cycle `!tx_active`. Owner never changes while `tx_active`.
- `tx_command_valid = ch_cmd_valid[tx_owner] && !fifo_full`; `tx_command`, `tx_data` = owner's slices.
- `ch_tx_*[i] = strobe && (tx_owner == i)`.
- `tx_command_started && ch_reply_wanted[tx_owner]`: push `tx_owner` into FIFO; `rr_ptr <= tx_owner+1` (mod NCH) on every `tx_command_started`.
- FIFO count width `$clog2(MAX_OUTSTANDING+1)`; full when count == MAX_OUTSTANDING. Pop on `rx_done`. Push+pop same cycle: count unchanged, head advances, tail written.
- Head tag stays valid until `rx_done` inclusive; `ch_rx_*[i] = strobe && !fifo_empty && head == i`.
- Any of `rx_started|rx_sbs_valid|rx_data_valid|rx_done` with FIFO empty: all `ch_rx_*` 0, pop suppressed, `rx_orphan <= 1`.

## Timing
- Reset: owner_q = 0, rr_ptr = 0, FIFO empty (count 0, pointers 0), rx_orphan = 0. Outputs then combinational from inputs: `fifo_empty`=1, `fifo_full`=0.
- Grant to `tx_command_valid`: 0 cycles (combinational) when idle.
- Push visible next cycle: `fifo_empty` falls cycle after `tx_command_started`; same-cycle `rx_done` of that entry impossible.
- Full gating: `tx_command_valid` low the cycle count reaches MAX_OUTSTANDING; high again cycle after `rx_done` pop.
- Reset mid-transaction: FIFO cleared, pending replies then raise `rx_orphan`.

## Test plan
- NCH=2, ARB_MODE=0, both valid, idle -> `tx_owner`=1, ch1 gets `ch_tx_command_started`; ch0 issued only after ch1 drops valid and `tx_active` falls.
- NCH=4, ARB_MODE=1, all four valid continuously, 8 reads -> owners 0,1,2,3,0,1,2,3 (rr_ptr wraps), each RX routed in same order.
- ch0 asserts `ch_reserve` across two transactions while ch1 valid -> ch1 never owner until reserve drops; then next started is ch1.
- MAX_OUTSTANDING=3, 3 reads started, no replies -> `fifo_full`=1, `tx_command_valid`=0 despite valid; one `rx_done` -> valid reasserted next cycle.
- Push and `rx_done` same cycle at count 2 -> count stays 2, next RX routed to second-oldest tag.
- `rx_started` with FIFO empty -> all `ch_rx_*`=0, `rx_orphan`=1 until `reset`.
